multicycle_ctrl: RTL and testbench

Multicycle RISC-V RV32I control FSM that sequences a shared-ALU / unified-memory datapath.
- Single ALU computes PC+4, branch targets, addresses and results across several cycles.
- Memory is one port with a ready handshake.
- Drives every datapath mux select and write enable. Resolves branch conditions from ALU flags. Flags illegal opcodes and memory timeouts.

---
 rtl/riscv_mc_pkg.sv | 67 ++++++
 rtl/mc_alu_dec.sv | 34 +++
 rtl/multicycle_ctrl.sv | 234 +++++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_mc_pkg.sv
// Shared types and encodings for the multicycle RV32I controller.
// Holds the FSM state type, opcodes, mux-select codes and the immediate-format decode.
package riscv_mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
        S_EXECR, S_EXECI, S_ALUWB, S_BRANCH, S_JAL, S_JALR,
        S_LINK, S_LUI, S_AUIPC, S_FAULT
    } state_t;

    // The ALU decoder either forces add/sub or decodes funct3 for EXECR/EXECI.
    typedef enum logic [1:0] {
        ALUC_ADD, ALUC_SUB, ALUC_FUNCT
    } alu_class_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLT  = 4'b0101;
    localparam logic [3:0] ALU_SRL  = 4'b0110;
    localparam logic [3:0] ALU_SRA  = 4'b0111;
    localparam logic [3:0] ALU_SLL  = 4'b1000;
    localparam logic [3:0] ALU_SLTU = 4'b1001;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALURES = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;
    localparam logic [1:0] SRCA_ZERO  = 2'b11;

    localparam logic [1:0] SRCB_RS2   = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;

    function automatic logic [2:0] imm_src_of(input logic [6:0] op);
        case (op)
            OP_LOAD, OP_ITYPE, OP_JALR: return IMM_I;
            OP_STORE:                   return IMM_S;
            OP_BRANCH:                  return IMM_B;
            OP_JAL:                     return IMM_J;
            OP_LUI, OP_AUIPC:           return IMM_U;
            default:                    return IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/mc_alu_dec.sv
// Combinational ALU operation decoder for the multicycle controller.
// Outside EXECR/EXECI the controller requests a fixed add or sub.
module mc_alu_dec
    import riscv_mc_pkg::*;
(
    input  alu_class_t  alu_class,
    input  logic [2:0]  funct3,
    input  logic        funct7b5,
    input  logic        op5,
    output logic [3:0]  ALUControl
);

    always_comb begin
        ALUControl = ALU_ADD;
        case (alu_class)
            ALUC_SUB: ALUControl = ALU_SUB;
            ALUC_FUNCT: begin
                case (funct3)
                    // Only R-type (op[5]=1) can subtract; addi ignores bit 30.
                    3'b000:  ALUControl = (funct7b5 && op5) ? ALU_SUB : ALU_ADD;
                    3'b001:  ALUControl = ALU_SLL;
                    3'b010:  ALUControl = ALU_SLT;
                    3'b011:  ALUControl = ALU_SLTU;
                    3'b100:  ALUControl = ALU_XOR;
                    3'b101:  ALUControl = funct7b5 ? ALU_SRA : ALU_SRL;
                    3'b110:  ALUControl = ALU_OR;
                    default: ALUControl = ALU_AND;
                endcase
            end
            default: ALUControl = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I control FSM sequencing a shared-ALU, single-port-memory datapath.
//
// state    | meaning
// FETCH    | read instruction at PC, PC <= PC+4 on MemReady
// DECODE   | ALUOut <= OldPC + imm (branch/jal target)
// MEMADR   | ALUOut <= rs1 + imm (load/store address)
// MEMREAD  | read data at ALUOut
// MEMWB    | rd <= Data
// MEMWRITE | write rs2 at ALUOut until MemReady
// EXECR    | rs1 op rs2
// EXECI    | rs1 op imm
// ALUWB    | rd <= ALUOut
// BRANCH   | compare rs1-rs2, PC <= target if taken
// JAL      | PC <= target, ALUOut <= OldPC+4
// JALR     | PC <= (rs1+imm) & ~1
// LINK     | ALUOut <= OldPC+4
// LUI      | ALUOut <= 0 + imm
// AUIPC    | ALUOut <= OldPC + imm
// FAULT    | illegal opcode or memory timeout; held until reset
module multicycle_ctrl
    import riscv_mc_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [6:0]  op,
    input  logic [2:0]  funct3,
    input  logic        funct7b5,
    input  logic        Zero,
    input  logic        Lt,
    input  logic        Ltu,
    input  logic        MemReady,
    output logic        PCWrite,
    output logic        AdrSrc,
    output logic        MemWrite,
    output logic        IRWrite,
    output logic        RegWrite,
    output logic [1:0]  ResultSrc,
    output logic [1:0]  ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [2:0]  ImmSrc,
    output logic [3:0]  ALUControl,
    output logic        PCLsbClr,
    output logic        InstrDone,
    output logic        Fault
);

    localparam logic [7:0] TIMEOUT_CNT = 8'(MEM_TIMEOUT);

    state_t     state, next_state;
    logic [7:0] wait_cnt;
    logic       mem_state, timeout, taken;
    alu_class_t alu_class;
    logic       pc_write, mem_write, ir_write, reg_write, pc_lsb_clr, instr_done;

    assign mem_state = (state == S_FETCH) || (state == S_MEMREAD) || (state == S_MEMWRITE);
    assign timeout   = mem_state && !MemReady && (wait_cnt == TIMEOUT_CNT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_FETCH;
            wait_cnt <= '0;
        end else begin
            state <= next_state;
            // Clearing on every transition covers entry into each memory state.
            if (next_state != state)
                wait_cnt <= '0;
            else if (mem_state && !MemReady)
                wait_cnt <= wait_cnt + 8'd1;
        end
    end

    always_comb begin
        taken = 1'b0;
        case (funct3)
            3'b000:  taken = Zero;
            3'b001:  taken = !Zero;
            3'b100:  taken = Lt;
            3'b101:  taken = !Lt;
            3'b110:  taken = Ltu;
            3'b111:  taken = !Ltu;
            default: taken = 1'b0;
        endcase
    end

    always_comb begin
        next_state = state;
        case (state)
            S_FETCH: begin
                if (timeout)       next_state = S_FAULT;
                else if (MemReady) next_state = S_DECODE;
            end
            S_DECODE: begin
                case (op)
                    OP_LOAD, OP_STORE: next_state = S_MEMADR;
                    OP_RTYPE:          next_state = S_EXECR;
                    OP_ITYPE:          next_state = S_EXECI;
                    OP_BRANCH:         next_state = S_BRANCH;
                    OP_JAL:            next_state = S_JAL;
                    OP_JALR:           next_state = S_JALR;
                    OP_LUI:            next_state = S_LUI;
                    OP_AUIPC:          next_state = S_AUIPC;
                    default:           next_state = S_FAULT;
                endcase
            end
            S_MEMADR:   next_state = op[5] ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD: begin
                if (timeout)       next_state = S_FAULT;
                else if (MemReady) next_state = S_MEMWB;
            end
            S_MEMWRITE: begin
                if (timeout)       next_state = S_FAULT;
                else if (MemReady) next_state = S_FETCH;
            end
            S_MEMWB:    next_state = S_FETCH;
            S_EXECR:    next_state = S_ALUWB;
            S_EXECI:    next_state = S_ALUWB;
            S_ALUWB:    next_state = S_FETCH;
            S_BRANCH:   next_state = S_FETCH;
            S_JAL:      next_state = S_ALUWB;
            S_JALR:     next_state = S_LINK;
            S_LINK:     next_state = S_ALUWB;
            S_LUI:      next_state = S_ALUWB;
            S_AUIPC:    next_state = S_ALUWB;
            default:    next_state = S_FAULT;
        endcase
    end

    always_comb begin
        pc_write   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        pc_lsb_clr = 1'b0;
        instr_done = 1'b0;
        AdrSrc     = 1'b0;
        ResultSrc  = RES_ALUOUT;
        ALUSrcA    = SRCA_PC;
        ALUSrcB    = SRCB_RS2;
        alu_class  = ALUC_ADD;
        case (state)
            S_FETCH: begin
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURES;
                ir_write  = MemReady;
                pc_write  = MemReady;
            end
            S_DECODE: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
            end
            S_MEMADR: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = SRCB_IMM;
            end
            S_MEMREAD: AdrSrc = 1'b1;
            S_MEMWB: begin
                ResultSrc  = RES_DATA;
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            S_MEMWRITE: begin
                AdrSrc     = 1'b1;
                mem_write  = 1'b1;
                instr_done = MemReady;
            end
            S_EXECR: begin
                ALUSrcA   = SRCA_RS1;
                alu_class = ALUC_FUNCT;
            end
            S_EXECI: begin
                ALUSrcA   = SRCA_RS1;
                ALUSrcB   = SRCB_IMM;
                alu_class = ALUC_FUNCT;
            end
            S_ALUWB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA    = SRCA_RS1;
                alu_class  = ALUC_SUB;
                pc_write   = taken;
                instr_done = 1'b1;
            end
            S_JAL: begin
                ALUSrcA  = SRCA_OLDPC;
                ALUSrcB  = SRCB_FOUR;
                pc_write = 1'b1;
            end
            S_JALR: begin
                ALUSrcA    = SRCA_RS1;
                ALUSrcB    = SRCB_IMM;
                ResultSrc  = RES_ALURES;
                pc_write   = 1'b1;
                pc_lsb_clr = 1'b1;
            end
            S_LINK: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_FOUR;
            end
            S_LUI: begin
                ALUSrcA = SRCA_ZERO;
                ALUSrcB = SRCB_IMM;
            end
            S_AUIPC: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
            end
            default: ;
        endcase
    end

    mc_alu_dec u_alu_dec (
        .alu_class  (alu_class),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .op5        (op[5]),
        .ALUControl (ALUControl)
    );

    assign ImmSrc = imm_src_of(op);

    // Strobes are gated by reset so nothing fires while it is asserted, even in FETCH.
    assign PCWrite   = pc_write   && !reset;
    assign MemWrite  = mem_write  && !reset;
    assign IRWrite   = ir_write   && !reset;
    assign RegWrite  = reg_write  && !reset;
    assign PCLsbClr  = pc_lsb_clr && !reset;
    assign InstrDone = instr_done && !reset;
    assign Fault     = (state == S_FAULT) && !reset;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: directed instruction scenarios followed by random instruction streams,
// each cycle's full control word compared against a per-instruction cycle table.
module tb_multicycle_ctrl;

    localparam int TMO = 15;

    localparam logic [3:0] A_ADD = 4'd0, A_SUB = 4'd1, A_AND = 4'd2, A_OR = 4'd3, A_XOR = 4'd4;
    localparam logic [3:0] A_SLT = 4'd5, A_SRL = 4'd6, A_SRA = 4'd7, A_SLL = 4'd8, A_SLTU = 4'd9;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5, Zero, Lt, Ltu, MemReady;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, PCLsbClr, InstrDone, Fault;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
    logic [2:0] ImmSrc;
    logic [3:0] ALUControl;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    multicycle_ctrl #(.MEM_TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .Zero(Zero), .Lt(Lt), .Ltu(Ltu), .MemReady(MemReady),
        .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ImmSrc(ImmSrc), .ALUControl(ALUControl), .PCLsbClr(PCLsbClr),
        .InstrDone(InstrDone), .Fault(Fault)
    );

    // {PCWrite,AdrSrc,MemWrite,IRWrite,RegWrite,ResultSrc,ALUSrcA,ALUSrcB,ImmSrc,ALUControl,PCLsbClr,InstrDone,Fault}
    logic [23:0] obs_w;
    assign obs_w = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA, ALUSrcB,
                    ImmSrc, ALUControl, PCLsbClr, InstrDone, Fault};

    function automatic logic [2:0] imm_of(input logic [6:0] o);
        case (o)
            7'h03, 7'h13, 7'h67: return 3'b000;
            7'h23:               return 3'b001;
            7'h63:               return 3'b010;
            7'h6F:               return 3'b011;
            7'h37, 7'h17:        return 3'b100;
            default:             return 3'b000;
        endcase
    endfunction

    function automatic logic [3:0] alu_of(input logic [2:0] f3, input logic f7, input logic [6:0] o);
        case (f3)
            3'd0: return (f7 && o == 7'h33) ? A_SUB : A_ADD;
            3'd1: return A_SLL;
            3'd2: return A_SLT;
            3'd3: return A_SLTU;
            3'd4: return A_XOR;
            3'd5: return f7 ? A_SRA : A_SRL;
            3'd6: return A_OR;
            default: return A_AND;
        endcase
    endfunction

    function automatic logic taken_of(input logic [2:0] f3, input logic z, input logic lt, input logic ltu);
        case (f3)
            3'd0: return z;
            3'd1: return !z;
            3'd4: return lt;
            3'd5: return !lt;
            3'd6: return ltu;
            3'd7: return !ltu;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [23:0] w(input logic pcw, input logic adr, input logic mw, input logic irw,
                                      input logic rw, input logic [1:0] rs, input logic [1:0] a,
                                      input logic [1:0] b, input logic [3:0] alu, input logic lsb,
                                      input logic done, input logic flt);
        return {pcw, adr, mw, irw, rw, rs, a, b, imm_of(op), alu, lsb, done, flt};
    endfunction

    task automatic check(input string tag, input logic [23:0] exp);
        n_cmp++;
        assert (obs_w === exp) else begin
            n_err++;
            $error("FAIL %s t=%0t observed=%h expected=%h", tag, $time, obs_w, exp);
        end
    endtask

    // Called at posedge+1; drives MemReady, checks mid-cycle, returns at next posedge+1.
    task automatic step(input logic rdy, input logic [23:0] exp, input string tag);
        MemReady = rdy;
        @(negedge clk);
        check(tag, exp);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        MemReady = 1'b1;
        #1;
        check("reset_outputs", w(0,0,0,0,0,2'd2,2'd0,2'd2,A_ADD,0,0,0));
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    function automatic logic rnd1();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic fault_hold(input int n);
        for (int i = 0; i < n; i++)
            step(rnd1(), w(0,0,0,0,0,2'd0,2'd0,2'd0,A_ADD,0,0,1), "fault_sticky");
    endtask

    task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                             input int fw, input int mw);
        logic [23:0] aluwb;
        op = o; funct3 = f3; funct7b5 = f7;
        aluwb = w(0,0,0,0,1,2'd0,2'd0,2'd0,A_ADD,0,1,0);
        for (int i = 0; i < fw; i++)
            step(0, w(0,0,0,0,0,2'd2,2'd0,2'd2,A_ADD,0,0,0), "fetch_wait");
        step(1, w(1,0,0,1,0,2'd2,2'd0,2'd2,A_ADD,0,0,0), "fetch");
        step(rnd1(), w(0,0,0,0,0,2'd0,2'd1,2'd1,A_ADD,0,0,0), "decode");
        case (o)
            7'h33: begin
                step(rnd1(), w(0,0,0,0,0,2'd0,2'd2,2'd0,alu_of(f3,f7,o),0,0,0), "execr");
                step(rnd1(), aluwb, "aluwb_r");
            end
            7'h13: begin
                step(rnd1(), w(0,0,0,0,0,2'd0,2'd2,2'd1,alu_of(f3,f7,o),0,0,0), "execi");
                step(rnd1(), aluwb, "aluwb_i");
            end
            7'h03: begin
                step(rnd1(), w(0,0,0,0,0,2'd0,2'd2,2'd1,A_ADD,0,0,0), "memadr_ld");
                for (int i = 0; i < mw; i++)
                    step(0, w(0,1,0,0,0,2'd0,2'd0,2'd0,A_ADD,0,0,0), "memread_wait");
                step(1, w(0,1,0,0,0,2'd0,2'd0,2'd0,A_ADD,0,0,0), "memread");
                step(rnd1(), w(0,0,0,0,1,2'd1,2'd0,2'd0,A_ADD,0,1,0), "memwb");
            end
            7'h23: begin
                step(rnd1(), w(0,0,0,0,0,2'd0,2'd2,2'd1,A_ADD,0,0,0), "memadr_st");
                for (int i = 0; i < mw; i++)
                    step(0, w(0,1,1,0,0,2'd0,2'd0,2'd0,A_ADD,0,0,0), "memwrite_wait");
                step(1, w(0,1,1,0,0,2'd0,2'd0,2'd0,A_ADD,0,1,0), "memwrite");
            end
            7'h63:
                step(rnd1(), w(taken_of(f3,Zero,Lt,Ltu),0,0,0,0,2'd0,2'd2,2'd0,A_SUB,0,1,0), "branch");
            7'h6F: begin
                step(rnd1(), w(1,0,0,0,0,2'd0,2'd1,2'd2,A_ADD,0,0,0), "jal");
                step(rnd1(), aluwb, "aluwb_jal");
            end
            7'h67: begin
                step(rnd1(), w(1,0,0,0,0,2'd2,2'd2,2'd1,A_ADD,1,0,0), "jalr");
                step(rnd1(), w(0,0,0,0,0,2'd0,2'd1,2'd2,A_ADD,0,0,0), "link");
                step(rnd1(), aluwb, "aluwb_jalr");
            end
            7'h37: begin
                step(rnd1(), w(0,0,0,0,0,2'd0,2'd3,2'd1,A_ADD,0,0,0), "lui");
                step(rnd1(), aluwb, "aluwb_lui");
            end
            7'h17: begin
                step(rnd1(), w(0,0,0,0,0,2'd0,2'd1,2'd1,A_ADD,0,0,0), "auipc");
                step(rnd1(), aluwb, "aluwb_auipc");
            end
            default: begin
                fault_hold(3);
                do_reset();
            end
        endcase
    endtask

    logic [6:0] legal_ops [9] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17};
    logic [6:0] bad_ops   [4] = '{7'h7F, 7'h00, 7'h0F, 7'h73};

    initial begin
        op = 7'h33; funct3 = 3'd0; funct7b5 = 1'b0;
        Zero = 1'b0; Lt = 1'b0; Ltu = 1'b0; MemReady = 1'b0;
        do_reset();

        // add x3,x1,x2
        run_instr(7'h33, 3'b000, 1'b0, 0, 0);
        // sub via funct7b5, addi must ignore funct7b5
        run_instr(7'h33, 3'b000, 1'b1, 0, 0);
        run_instr(7'h13, 3'b000, 1'b1, 0, 0);
        // lw with three wait cycles in MEMREAD
        run_instr(7'h03, 3'b010, 1'b0, 0, 3);
        // bne not-equal / equal, bgeu with Ltu=1
        Zero = 1'b0; run_instr(7'h63, 3'b001, 1'b0, 0, 0);
        Zero = 1'b1; run_instr(7'h63, 3'b001, 1'b0, 0, 0);
        Ltu  = 1'b1; run_instr(7'h63, 3'b111, 1'b0, 0, 0);
        // jalr
        run_instr(7'h67, 3'b000, 1'b0, 0, 0);
        // illegal opcode
        run_instr(7'h7F, 3'b000, 1'b0, 0, 0);

        // fetch timeout: 16 cycles without MemReady then FAULT
        op = 7'h33;
        for (int i = 0; i <= TMO; i++)
            step(0, w(0,0,0,0,0,2'd2,2'd0,2'd2,A_ADD,0,0,0), "fetch_to_timeout");
        fault_hold(4);
        do_reset();

        // store with a wait just short of the timeout
        run_instr(7'h23, 3'b010, 1'b0, 2, TMO);

        // reset asserted while MemWrite is high
        op = 7'h23; funct3 = 3'b010;
        step(1, w(1,0,0,1,0,2'd2,2'd0,2'd2,A_ADD,0,0,0), "fetch_sw");
        step(0, w(0,0,0,0,0,2'd0,2'd1,2'd1,A_ADD,0,0,0), "decode_sw");
        step(0, w(0,0,0,0,0,2'd0,2'd2,2'd1,A_ADD,0,0,0), "memadr_sw");
        MemReady = 1'b0;
        @(negedge clk);
        check("memwrite_before_reset", w(0,1,1,0,0,2'd0,2'd0,2'd0,A_ADD,0,0,0));
        #2 reset = 1'b1;
        #1 check("memwrite_async_drop", w(0,0,0,0,0,2'd2,2'd0,2'd2,A_ADD,0,0,0));
        @(posedge clk);
        #1 reset = 1'b0;
        step(1, w(1,0,0,1,0,2'd2,2'd0,2'd2,A_ADD,0,0,0), "fetch_after_reset");
        step(0, w(0,0,0,0,0,2'd0,2'd1,2'd1,A_ADD,0,0,0), "decode_after_reset");
        step(0, w(0,0,0,0,0,2'd0,2'd2,2'd1,A_ADD,0,0,0), "memadr_after_reset");
        step(1, w(0,1,1,0,0,2'd0,2'd0,2'd0,A_ADD,0,1,0), "memwrite_after_reset");

        // random instruction stream
        for (int n = 0; n < 200; n++) begin
            logic [6:0] o;
            Zero = rnd1(); Lt = rnd1(); Ltu = rnd1();
            if ($urandom_range(0, 19) == 0)
                o = bad_ops[$urandom_range(0, 3)];
            else
                o = legal_ops[$urandom_range(0, 8)];
            run_instr(o, 3'($urandom_range(0, 7)), rnd1(),
                      $urandom_range(0, 4), $urandom_range(0, 6));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
